// File: rtl/counter_overflow_checker.sv
// Passive safety monitor for a WIDTH-bit wrapping counter: tracks a reference count,
// flags value/overflow mismatches, counts wraps and errors. Optional macro: COUNTER_CHECK_RESYNC_EN.
module counter_overflow_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] counter_in,
  input  logic             overflow_in,
  output logic [WIDTH-1:0] expected_out,
  output logic             mismatch_out,
  output logic             error_sticky,
  output logic [CNT_W-1:0] overflow_count,
  output logic [CNT_W-1:0] error_count,
  output logic [1:0]       state_out
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_exp;
  logic             r_mismatch;
  logic             r_sticky;
  logic [CNT_W-1:0] r_ovf_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_val_err;
  logic             w_ovf_err;
  logic             w_fail;
  logic             w_wrap;
  logic [WIDTH-1:0] w_exp_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Per-sample checks and next reference value
  always_comb begin
    w_val_err  = (counter_in != r_exp);
    w_ovf_err  = (overflow_in != (counter_in == MAX_VAL));
    w_fail     = w_val_err | w_ovf_err;
    w_wrap     = enable_in & (counter_in == MAX_VAL) & overflow_in;
    w_exp_next = r_exp + {{(WIDTH-1){1'b0}}, enable_in};
`ifdef COUNTER_CHECK_RESYNC_EN
    // Re-seed from the observed value so a single glitch costs exactly one error
    if (w_fail) begin
      w_exp_next = counter_in + {{(WIDTH-1){1'b0}}, enable_in};
    end else begin
      w_exp_next = r_exp + {{(WIDTH-1){1'b0}}, enable_in};
    end
`endif
  end

  // Reference count, status FSM and saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_exp      <= {WIDTH{1'b0}};
      r_mismatch <= 1'b0;
      r_sticky   <= 1'b0;
      r_ovf_cnt  <= {CNT_W{1'b0}};
      r_err_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_exp      <= w_exp_next;
      r_mismatch <= w_fail;
      r_sticky   <= r_sticky | w_fail;
      r_ovf_cnt  <= w_wrap ? sat_inc(r_ovf_cnt) : r_ovf_cnt;
      r_err_cnt  <= w_fail ? sat_inc(r_err_cnt) : r_err_cnt;
      case (r_state)
        IDLE:    r_state <= w_fail ? FAULT : RUN;
        RUN:     r_state <= w_fail ? FAULT : RUN;
        FAULT:   r_state <= FAULT;
        default: r_state <= FAULT;
      endcase
    end
  end

  assign expected_out   = r_exp;
  assign mismatch_out   = r_mismatch;
  assign error_sticky   = r_sticky;
  assign overflow_count = r_ovf_cnt;
  assign error_count    = r_err_cnt;
  assign state_out      = r_state;

endmodule

// File: tb/tb_counter_overflow_checker.sv
// Self-checking bench for counter_overflow_checker: directed scenarios plus random traffic
// compared against an arithmetic reference model; honours COUNTER_CHECK_RESYNC_EN.
module tb_counter_overflow_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable_in = 1'b0;
  logic [3:0] counter_in = 4'd0;
  logic       overflow_in = 1'b0;
  logic [3:0] expected_out;
  logic       mismatch_out;
  logic       error_sticky;
  logic [7:0] overflow_count;
  logic [7:0] error_count;
  logic [1:0] state_out;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: plain integers
  int m_exp, m_mis, m_stk, m_ovf, m_err, m_st;
  // the "real" counter the checker is watching
  int rc;

  counter_overflow_checker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable_in(enable_in), .counter_in(counter_in),
    .overflow_in(overflow_in), .expected_out(expected_out), .mismatch_out(mismatch_out),
    .error_sticky(error_sticky), .overflow_count(overflow_count),
    .error_count(error_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] dut_vec();
    return {expected_out, mismatch_out, error_sticky, overflow_count, error_count, state_out};
  endfunction

  function automatic logic [23:0] mdl_vec();
    return {4'(m_exp), 1'(m_mis), 1'(m_stk), 8'(m_ovf), 8'(m_err), 2'(m_st)};
  endfunction

  // drive one sample, clock it, advance the model, and settle
  task automatic step(input bit rst, input bit en, input int cnt, input bit ovf);
    bit fail;
    reset = rst; enable_in = en; counter_in = 4'(cnt); overflow_in = ovf;
    @(posedge clk);
    if (rst) begin
      m_exp = 0; m_mis = 0; m_stk = 0; m_ovf = 0; m_err = 0; m_st = 0;
    end else begin
      fail = (cnt != m_exp) || (ovf != (cnt == 15));
      if (en && cnt == 15 && ovf) m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
      if (fail) m_err = (m_err < 255) ? m_err + 1 : 255;
      m_mis = fail;
      if (fail) m_stk = 1;
      if (fail) m_st = 2; else if (m_st != 2) m_st = 1;
`ifdef COUNTER_CHECK_RESYNC_EN
      m_exp = fail ? (cnt + en) % 16 : (m_exp + en) % 16;
`else
      m_exp = (m_exp + en) % 16;
`endif
    end
    #1;
  endtask

  task automatic good_step(input bit en);
    step(1'b0, en, rc, rc == 15);
    rc = (rc + en) % 16;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 0, 1'b0);
      n_cmp++;
      if (dut_vec() !== 24'h0) begin
        n_bad++; $display("FAIL reset: got %h want %h", dut_vec(), 24'h0);
      end
    end
    rc = 0;
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 5; i++) begin
      good_step(1'b0);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL idle_hold[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    n_cmp++;
    if (state_out !== 2'b01 || mismatch_out !== 1'b0 || error_count !== 8'd0) begin
      n_bad++; $display("FAIL idle_run: got st=%b mis=%b err=%0d want st=01 mis=0 err=0",
                        state_out, mismatch_out, error_count);
    end
  endtask

  task automatic test_count_wrap();
    step(1'b1, 1'b0, 0, 1'b0); rc = 0;
    for (int i = 0; i < 20; i++) begin
      good_step(1'b1);
      n_cmp++;
      if (dut_vec() !== mdl_vec() || expected_out !== 4'(rc)) begin
        n_bad++; $display("FAIL count_wrap[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    n_cmp++;
    if (overflow_count !== 8'd1 || error_count !== 8'd0) begin
      n_bad++; $display("FAIL wrap_total: got ovf=%0d err=%0d want ovf=1 err=0",
                        overflow_count, error_count);
    end
  endtask

  task automatic test_glitch();
    step(1'b1, 1'b0, 0, 1'b0); rc = 0;
    for (int i = 0; i < 3; i++) good_step(1'b1);
    step(1'b0, 1'b1, 5, 1'b0);
    n_cmp++;
    if (mismatch_out !== 1'b1 || error_sticky !== 1'b1 || state_out !== 2'b10 || dut_vec() !== mdl_vec()) begin
      n_bad++; $display("FAIL glitch_hit: got %h want %h", dut_vec(), mdl_vec());
    end
    rc = 6;
    for (int i = 0; i < 4; i++) begin
      good_step(1'b1);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL glitch_after[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    n_cmp++;
`ifdef COUNTER_CHECK_RESYNC_EN
    if (error_count !== 8'd1 || mismatch_out !== 1'b0) begin
      n_bad++; $display("FAIL glitch_total: got err=%0d want 1", error_count);
    end
`else
    if (error_count !== 8'd5 || mismatch_out !== 1'b1) begin
      n_bad++; $display("FAIL glitch_total: got err=%0d want 5", error_count);
    end
`endif
  endtask

  task automatic test_bad_overflow();
    step(1'b1, 1'b0, 0, 1'b0); rc = 0;
    for (int i = 0; i < 7; i++) good_step(1'b1);
    step(1'b0, 1'b1, 7, 1'b1);
    n_cmp++;
    if (dut_vec() !== mdl_vec() || error_count !== 8'd1 || overflow_count !== 8'd0 || expected_out !== 4'd8) begin
      n_bad++; $display("FAIL bad_overflow: got %h want %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_saturate();
    step(1'b1, 1'b0, 0, 1'b0); rc = 0;
    for (int i = 0; i < 300 * 16; i++) begin
      good_step(1'b1);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL saturate[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    n_cmp++;
    if (overflow_count !== 8'd255 || error_count !== 8'd0) begin
      n_bad++; $display("FAIL saturate_total: got ovf=%0d err=%0d want 255/0",
                        overflow_count, error_count);
    end
  endtask

  task automatic test_reset_in_fault();
    int bad;
    step(1'b1, 1'b0, 0, 1'b0); rc = 0;
    for (int i = 0; i < 4; i++) begin
      bad = (m_exp + 1 + int'($urandom_range(0, 13))) % 16;
      step(1'b0, 1'b0, bad, bad == 15);
    end
    n_cmp++;
    if (error_count !== 8'd4 || state_out !== 2'b10) begin
      n_bad++; $display("FAIL fault_setup: got err=%0d st=%b want 4/10", error_count, state_out);
    end
    step(1'b1, 1'b1, 3, 1'b1); rc = 0;
    n_cmp++;
    if (dut_vec() !== 24'h0) begin
      n_bad++; $display("FAIL fault_reset: got %h want %h", dut_vec(), 24'h0);
    end
    for (int i = 0; i < 3; i++) good_step(1'b1);
    n_cmp++;
    if (state_out !== 2'b01 || dut_vec() !== mdl_vec()) begin
      n_bad++; $display("FAIL fault_recover: got %h want %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_random();
    bit rst, en, ovf;
    int cnt;
    step(1'b1, 1'b0, 0, 1'b0); rc = 0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      en  = $urandom_range(0, 3) != 0;
      cnt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : rc;
      ovf = (cnt == 15) ^ ($urandom_range(0, 15) == 0);
      step(rst, en, cnt, ovf);
      rc = rst ? 0 : (rc + en) % 16;
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_count_wrap();
    test_glitch();
    test_bad_overflow();
    test_saturate();
    test_reset_in_fault();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
